// File: rtl/psdsqrt_rnd.sv
// psdsqrt_rnd: bit-serial integer square root with guard bits, selectable rounding and saturation
module psdsqrt_rnd #(
   parameter int NBITSIN = 32,
   parameter int FRACB   = 4,
   parameter int RMODE   = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [NBITSIN-1:0] xin,
   output logic               busy,
   output logic               done,
   output logic [NBITSIN/2-1:0] sqrt,
   output logic               exact,
   output logic               sat
);
   localparam int NH = NBITSIN / 2;
   localparam int W  = NH + FRACB;
   localparam int CW = $clog2(W);

   generate
      if (NBITSIN % 2 != 0 || NBITSIN < 4 || NBITSIN > 62) begin : g_bad_nbitsin
         $error("psdsqrt_rnd: NBITSIN must be even and within 4..62");
      end
      if (FRACB < 1 || FRACB > 8) begin : g_bad_fracb
         $error("psdsqrt_rnd: FRACB must be within 1..8");
      end
      if (RMODE < 0 || RMODE > 2) begin : g_bad_rmode
         $error("psdsqrt_rnd: RMODE must be 0, 1 or 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, ROUND} state_t;

   state_t           r_state, w_next;
   logic [2*W-1:0]   r_x;
   logic [W-1:0]     r_q;
   logic [W+1:0]     r_rem;
   logic [CW-1:0]    r_cnt;
   logic [W+1:0]     w_part, w_trial;
   logic             w_fits, w_exact, w_inc;
   logic [NH:0]      w_v;

   // Remainder form of the digit recurrence: the remainder never exceeds 2*root,
   // so its top two bits are always zero before the next operand pair is shifted in.
   assign w_part  = {r_rem[W-1:0], r_x[2*W-1 -: 2]};
   assign w_trial = {r_q, 2'b01};
   assign w_fits  = w_part >= w_trial;
   assign w_exact = r_rem == '0;
   // Round-to-nearest only needs the top guard bit; ceiling bumps on any inexact result.
   assign w_inc   = RMODE == 1 ? r_q[FRACB-1] :
                    RMODE == 2 ? (|r_q[FRACB-1:0] | !w_exact) : 1'b0;
   assign w_v     = {1'b0, r_q[W-1:FRACB]} + {{NH{1'b0}}, w_inc};
   assign busy    = r_state != IDLE;

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state: accept a start while idle, iterate W times, then one rounding cycle
   always_comb begin
      w_next = r_state == IDLE ? (start ? CALC : IDLE) :
               r_state == CALC ? (r_cnt == CW'(W - 1) ? ROUND : CALC) : IDLE;
   end

   // Datapath: operand capture, one root bit per CALC cycle, rounding and result registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_x   <= '0;
         r_q   <= '0;
         r_rem <= '0;
         r_cnt <= '0;
         done  <= 1'b0;
         sqrt  <= '0;
         exact <= 1'b0;
         sat   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_x   <= {xin, {2*FRACB{1'b0}}};
               r_q   <= '0;
               r_rem <= '0;
               r_cnt <= '0;
            end
            CALC: begin
               r_x   <= r_x << 2;
               r_q   <= {r_q[W-2:0], w_fits};
               r_rem <= w_fits ? w_part - w_trial : w_part;
               r_cnt <= r_cnt + 1'b1;
            end
            ROUND: begin
               sqrt  <= w_v[NH] ? '1 : w_v[NH-1:0];
               sat   <= w_v[NH];
               exact <= w_exact;
               done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_psdsqrt_rnd.sv
// tb_psdsqrt_rnd: vector table, directed sequences and random checks against a real-sqrt model
module tb_psdsqrt_rnd;
   logic        clock = 1'b0, reset = 1'b1, start = 1'b0, start8 = 1'b0;
   logic [31:0] xin = '0;
   logic [7:0]  xin8 = '0;
   logic        busy[3], done[3], exact[3], sat[3];
   logic [15:0] sqrt[3];
   logic        busy8, done8, exact8, sat8;
   logic [3:0]  sqrt8;
   int          nchk = 0, nerr = 0, overlap = 0;

   always #5 clock = ~clock;

   psdsqrt_rnd #(.RMODE(0)) d0 (.clock(clock), .reset(reset), .start(start), .xin(xin),
      .busy(busy[0]), .done(done[0]), .sqrt(sqrt[0]), .exact(exact[0]), .sat(sat[0]));
   psdsqrt_rnd #(.RMODE(1)) d1 (.clock(clock), .reset(reset), .start(start), .xin(xin),
      .busy(busy[1]), .done(done[1]), .sqrt(sqrt[1]), .exact(exact[1]), .sat(sat[1]));
   psdsqrt_rnd #(.RMODE(2)) d2 (.clock(clock), .reset(reset), .start(start), .xin(xin),
      .busy(busy[2]), .done(done[2]), .sqrt(sqrt[2]), .exact(exact[2]), .sat(sat[2]));
   psdsqrt_rnd #(.NBITSIN(8), .FRACB(2), .RMODE(1)) d8 (.clock(clock), .reset(reset),
      .start(start8), .xin(xin8), .busy(busy8), .done(done8), .sqrt(sqrt8), .exact(exact8),
      .sat(sat8));

   typedef struct {
      logic [31:0] x;
      logic [15:0] s0, s1, s2;
      logic [2:0]  sat;
      logic        ex;
   } vec_t;

   task automatic chk(input string n, input longint unsigned a, input longint unsigned e);
      nchk++;
      if (a != e) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   function automatic longint unsigned isqrt(input longint unsigned v);
      longint unsigned lo = 0, hi = 64'd1 << 20, mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= v) lo = mid;
         else hi = mid;
      end
      return lo;
   endfunction

   // Reference from real-valued rules: floor, nearest (via sqrt(4x)), ceiling; clamp at 2^16
   task automatic model(input logic [31:0] x, input int m, output logic [15:0] s,
                        output logic st, output logic ex);
      longint unsigned r, v;
      r  = isqrt(64'(x));
      ex = (r * r == 64'(x));
      v  = m == 0 ? r : m == 1 ? (isqrt(64'(x) * 4) + 1) / 2 : r + ((r * r != 64'(x)) ? 1 : 0);
      st = v >= 65536;
      s  = st ? 16'hFFFF : v[15:0];
   endtask

   always @(posedge clock) #1 if (busy[1] && done[1]) overlap++;

   task automatic launch(input logic [31:0] x);
      @(negedge clock);
      xin   = x;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done[1] && lat < 60) begin
         @(posedge clock);
         #1 lat++;
      end
   endtask

   initial begin
      vec_t        tbl[6];
      int          lat, k, gaps, ndone;
      logic [15:0] es;
      logic        est, eex;
      logic [31:0] rx;
      tbl[0] = '{32'd0,          16'd0,      16'd0,      16'd0,      3'b000, 1'b1};
      tbl[1] = '{32'd16,         16'd4,      16'd4,      16'd4,      3'b000, 1'b1};
      tbl[2] = '{32'd10,         16'd3,      16'd3,      16'd4,      3'b000, 1'b0};
      tbl[3] = '{32'd13,         16'd3,      16'd4,      16'd4,      3'b000, 1'b0};
      tbl[4] = '{32'd12,         16'd3,      16'd3,      16'd4,      3'b000, 1'b0};
      tbl[5] = '{32'hFFFF_FFFF,  16'hFFFF,   16'hFFFF,   16'hFFFF,   3'b110, 1'b0};
      repeat (3) @(posedge clock);
      #1;
      chk("reset busy", busy[1], 0);
      chk("reset done", done[1], 0);
      chk("reset sqrt", sqrt[1], 0);
      chk("reset exact", exact[1], 0);
      chk("reset sat", sat[1], 0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         launch(tbl[i].x);
         chk($sformatf("busy after start x=%0h", tbl[i].x), busy[1], 1);
         wait_done(lat);
         chk($sformatf("latency x=%0h", tbl[i].x), lat, 21);
         chk($sformatf("busy at done x=%0h", tbl[i].x), busy[1], 0);
         chk($sformatf("sqrt m0 x=%0h", tbl[i].x), sqrt[0], tbl[i].s0);
         chk($sformatf("sqrt m1 x=%0h", tbl[i].x), sqrt[1], tbl[i].s1);
         chk($sformatf("sqrt m2 x=%0h", tbl[i].x), sqrt[2], tbl[i].s2);
         chk($sformatf("sat x=%0h", tbl[i].x), {sat[2], sat[1], sat[0]}, tbl[i].sat);
         chk($sformatf("exact x=%0h", tbl[i].x), exact[1], tbl[i].ex);
         @(posedge clock);
         #1 chk($sformatf("done one cycle x=%0h", tbl[i].x), done[1], 0);
      end
      // start re-pulsed mid-operation with a different operand must be ignored
      launch(32'd100);
      k = 0;
      gaps = 0;
      while (!done[1] && k < 60) begin
         @(negedge clock);
         start = (k == 4 || k == 9);
         xin   = start ? 32'd9 : 32'd100;
         @(posedge clock);
         #1 k++;
         if (!done[1] && !busy[1]) gaps++;
      end
      start = 1'b0;
      chk("repulse latency", k, 21);
      chk("repulse busy gaps", gaps, 0);
      chk("repulse sqrt", sqrt[1], 10);
      // start in the done cycle is accepted
      xin   = 32'd49;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      chk("b2b busy", busy[1], 1);
      chk("b2b outputs hold", sqrt[1], 10);
      wait_done(lat);
      chk("b2b latency", lat, 21);
      chk("b2b sqrt", sqrt[1], 7);
      chk("b2b exact", exact[1], 1);
      // reset in the middle of a computation
      launch(32'd200);
      repeat (7) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("abort busy", busy[1], 0);
      chk("abort sqrt", sqrt[1], 0);
      chk("abort exact", exact[1], 0);
      @(negedge clock);
      reset = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(posedge clock);
         #1 if (done[1]) ndone++;
      end
      chk("abort no done", ndone, 0);
      // reset and start together: reset wins
      @(negedge clock);
      reset = 1'b1;
      start = 1'b1;
      xin   = 32'd81;
      @(posedge clock);
      #1;
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      @(posedge clock);
      #1 chk("reset beats start", busy[1], 0);
      // narrow instance
      @(negedge clock);
      xin8   = 8'd255;
      start8 = 1'b1;
      @(posedge clock);
      #1 start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 30) begin
         @(posedge clock);
         #1 lat++;
      end
      chk("n8 latency", lat, 7);
      chk("n8 sqrt", sqrt8, 15);
      chk("n8 sat", sat8, 1);
      chk("n8 exact", exact8, 0);
      // random operands against the model
      for (int i = 0; i < 30; i++) begin
         rx = i % 3 == 0 ? $urandom : i % 3 == 1 ? $urandom_range(0, 1000) : $urandom_range(0, 65535) ** 2;
         launch(rx);
         wait_done(lat);
         chk($sformatf("rnd latency x=%0h", rx), lat, 21);
         for (int m = 0; m < 3; m++) begin
            model(rx, m, es, est, eex);
            chk($sformatf("rnd sqrt m%0d x=%0h", m, rx), sqrt[m], es);
            chk($sformatf("rnd sat m%0d x=%0h", m, rx), sat[m], est);
            chk($sformatf("rnd exact m%0d x=%0h", m, rx), exact[m], eex);
         end
      end
      chk("busy and done overlap", overlap, 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/psdsqrt_rnd.md
# psdsqrt_rnd

Parametrised bit-serial integer square-root unit: successor to the fixed 32-bit, stop-strobed square-root block. It computes floor(sqrt(xin·4^FRACB)) one bit per clock, then applies a selectable rounding mode and saturates to the output width. It exposes a start/busy/done handshake, so the datapath controller no longer times an external stop strobe. It sits between the operand register file and the result bus in the arithmetic datapath.

## Interface
- NBITSIN, 32, operand width; must be even and in 4..62, otherwise elaboration fails.
- FRACB, 4, guard (fractional) result bits used for rounding; range 1..8.
- RMODE, 1, rounding mode: 0 = truncate (floor), 1 = round-to-nearest, 2 = ceiling.
- clock  input  1  master clock, rising edge.
- reset  input  1  synchronous reset, active high.
- start  input  1  start request, sampled on a rising edge while idle.
- xin  input  NBITSIN  unsigned operand.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when sqrt/exact/sat are updated.
- sqrt  output  NBITSIN/2  rounded, saturated unsigned root.
- exact  output  1  xin is a perfect square.
- sat  output  1  rounding overflowed and sqrt was clamped.

## Operation
- Internal widths:
  - X = {xin, 2·FRACB zeros}, NBITSIN+2·FRACB bits.
  - R is W = NBITSIN/2+FRACB bits.
  - I = R[W-1:FRACB] (integer part); F = R[FRACB-1:0] (fraction); H = 1<<(FRACB-1).
- States: IDLE, CALC, ROUND.
- IDLE:
  - start=1 latches X and clears R and the trial-bit mask (mask = 1<<(W-1)).
  - Clears the iteration counter and moves to CALC.
- CALC runs W cycles, MSB first. Each cycle:
  - T = R | mask.
  - If T·T <= X, then R <= T.
  - mask shifts right by 1.
  - An equivalent non-restoring/remainder formulation is acceptable if final R = floor(sqrt(X)) bit-exactly.
  - After the W-th iteration, go to ROUND.
- ROUND lasts one cycle. E = (R·R == X).
  - RMODE 0: V = I.
  - RMODE 1: V = I + (F >= H). A true tie cannot occur for integer xin.
  - RMODE 2: V = I + ((F != 0) | !E).
  - If V = 2^(NBITSIN/2), then sqrt <= all ones and sat <= 1; else sqrt <= V and sat <= 0.
  - exact <= E, done <= 1, return to IDLE.
- Outputs sqrt/exact/sat hold their value until the next done; they do not change during CALC.
- start while busy=1 is ignored; no queuing.
- xin is sampled only on the accepting edge and may change afterwards.

## Timing
- Reset: state IDLE; busy, done, sqrt, exact and sat are 0; internal registers are 0.
- Reset mid-operation aborts the computation: no done pulse, outputs cleared.
- Start accepted at edge e0:
  - busy=1 from e0 through the edge at which done rises.
  - CALC iterations occur at edges e1..eW; ROUND registers results at e(W+1).
  - done=1 and busy=0 in the cycle following e(W+1).
  - Latency is W+1 clocks (21 at defaults).
- Back-to-back operation: start asserted during the done cycle is accepted, because the state is IDLE. The next done comes W+1 clocks later, so throughput is one result per W+1 clocks.
- done is high for exactly one cycle. busy and done are never high together.
- Reset and start asserted together: reset wins.

## Test plan
- Defaults, xin=0 → done after 21 clocks; sqrt=0, exact=1, sat=0. xin=16 → sqrt=4, exact=1.
- xin=10 (√≈3.162), repeated for RMODE 0/1/2 → sqrt=3/3/4, exact=0.
- xin=13 (√≈3.606), RMODE 0/1/2 → sqrt=3/4/4. xin=12 (√≈3.464) → 3/3/4.
- xin=32'hFFFF_FFFF:
  - RMODE 0 → sqrt=16'hFFFF, sat=0.
  - RMODE 1 and RMODE 2 → sqrt=16'hFFFF, sat=1, exact=0.
- Start re-pulsed at cycles 5 and 10 of an operation on xin=100 → single done at cycle 21 with sqrt=10; busy stays continuous. Then start in the done cycle with xin=49 → sqrt=7 21 clocks later.
- Reset asserted at CALC cycle 8 → busy=0 and outputs 0 the next cycle; no done follows. NBITSIN=8, FRACB=2, xin=255, RMODE 1 → W=6, done after 7 clocks, sqrt=15, sat=1.
